// File: rtl/vga_fb_fill_if.sv
// AXI4 write-channel bundle between the framebuffer fill engine (master)
// and the memory interconnect (slave).
interface vga_fb_fill_if;
  logic        awready;
  logic        awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wready;
  logic        wvalid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bready;
  logic        bvalid;
  logic [1:0]  bresp;

  modport master (
    input  awready, wready, bvalid, bresp,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready
  );

  modport slave (
    output awready, wready, bvalid, bresp,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready
  );
endinterface

// File: rtl/vga_fb_fill.sv
// Framebuffer fill engine: writes a solid-colour rectangle, one AXI4 INCR burst per row.
// Optional cycle counter on register 6 when VGA_FB_FILL_PERF_EN is defined.
module vga_fb_fill #(
  parameter logic [3:0] AXI_ID    = 4'd0,
  parameter int         MAX_BEATS = 256
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          reg_wen,
  input  logic [2:0]    reg_addr,
  input  logic [31:0]   reg_wdata,
  output logic [31:0]   reg_rdata,
  output logic          irq,
  vga_fb_fill_if.master io_master
);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  localparam logic [9:0] MAX_W = 10'(MAX_BEATS);

  state_t      state_q, state_d;
  logic        irq_en, done, err;
  logic [31:0] dst, stride, color;
  logic [8:0]  width;
  logic [9:0]  height;
  logic [31:0] row_addr;
  logic [9:0]  rows_left;
  logic [7:0]  beat;

  logic [8:0]  width_m1;
  logic        start_req, size_zero, size_big, start_ok;
  logic        b_hs, b_err, b_fin, set_done, set_err, last_beat, cfg_wr;

  assign width_m1  = width - 9'd1;
  assign last_beat = (beat == width_m1[7:0]);
  assign start_req = reg_wen && (reg_addr == 3'd0) && reg_wdata[0] && (state_q == IDLE);
  assign size_zero = (width == 9'd0) || (height == 10'd0);
  assign size_big  = ({1'b0, width} > MAX_W);
  assign start_ok  = start_req && !size_zero && !size_big;
  assign b_hs      = (state_q == B) && io_master.bvalid;
  assign b_err     = b_hs && (io_master.bresp != 2'b00);
  assign b_fin     = b_hs && (io_master.bresp == 2'b00) && (rows_left == 10'd1);
  assign set_done  = (start_req && (size_zero || size_big)) || b_err || b_fin;
  assign set_err   = (start_req && !size_zero && size_big) || b_err;
  assign cfg_wr    = reg_wen && (state_q == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = AW;
      AW:   if (io_master.awready) state_d = W;
      W:    if (io_master.wready && last_beat) state_d = B;
      B:    if (io_master.bvalid)
              state_d = (b_err || rows_left == 10'd1) ? IDLE : AW;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: bus outputs decode the state register alone, so the async reset
  // silences them immediately without waiting for a clock edge.
  assign io_master.awvalid = (state_q == AW);
  assign io_master.awaddr  = row_addr;
  assign io_master.awid    = AXI_ID;
  assign io_master.awlen   = width_m1[7:0];
  assign io_master.awsize  = 3'd3;
  assign io_master.awburst = 2'd1;
  assign io_master.wvalid  = (state_q == W);
  assign io_master.wdata   = {color, color};
  assign io_master.wstrb   = 8'hFF;
  assign io_master.wlast   = (state_q == W) && last_beat;
  assign io_master.bready  = (state_q == B);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_addr  <= '0;
      rows_left <= '0;
      beat      <= '0;
    end else begin
      if (start_ok) begin
        row_addr  <= dst;
        rows_left <= height;
      end
      if (state_q == AW && io_master.awready) beat <= '0;
      if (state_q == W && io_master.wready)   beat <= beat + 8'd1;
      if (b_hs && !b_err) begin
        row_addr  <= row_addr + stride;
        rows_left <= rows_left - 10'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      irq    <= 1'b0;
      dst    <= '0;
      width  <= '0;
      height <= '0;
      stride <= '0;
      color  <= '0;
    end else begin
      if (reg_wen && reg_addr == 3'd0) irq_en <= reg_wdata[1];
      if (cfg_wr) begin
        case (reg_addr)
          3'd2: dst <= reg_wdata;
          3'd3: begin
            width  <= reg_wdata[8:0];
            height <= reg_wdata[25:16];
          end
          3'd4: stride <= reg_wdata;
          3'd5: color  <= reg_wdata;
          default: ;
        endcase
      end
      if (reg_wen && reg_addr == 3'd1) begin
        if (reg_wdata[1]) done <= 1'b0;
        if (reg_wdata[2]) err  <= 1'b0;
      end
      if (start_ok) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      // NOTE: sets come last so a completion in the same cycle as a CPU clear wins.
      if (set_done) done <= 1'b1;
      if (set_err)  err  <= 1'b1;
      irq <= irq_en & done;
    end
  end

`ifdef VGA_FB_FILL_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                        perf_cnt <= '0;
    else if (start_ok)                                perf_cnt <= '0;
    else if (state_q != IDLE && perf_cnt != '1)       perf_cnt <= perf_cnt + 32'd1;
  end
`endif

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0: reg_rdata = {30'd0, irq_en, 1'b0};
      3'd1: reg_rdata = {29'd0, err, done, (state_q != IDLE)};
      3'd2: reg_rdata = dst;
      3'd3: reg_rdata = {6'd0, height, 7'd0, width};
      3'd4: reg_rdata = stride;
      3'd5: reg_rdata = color;
`ifdef VGA_FB_FILL_PERF_EN
      3'd6: reg_rdata = perf_cnt;
`endif
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_vga_fb_fill.sv
// Self-checking bench for vga_fb_fill: reactive AXI write slave plus a
// row/beat scoreboard derived from the rectangle geometry.
module tb_vga_fb_fill;

  logic        clock = 1'b0;
  logic        reset;
  logic        reg_wen;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq;

  vga_fb_fill_if bus ();

  vga_fb_fill dut (
    .clock     (clock),
    .reset     (reset),
    .reg_wen   (reg_wen),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq),
    .io_master (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // slave behaviour knobs
  int aw_stall = 0;
  bit w_toggle = 1'b0;
  int err_row  = -1;

  // slave bookkeeping
  int aw_wait   = 0;
  bit b_wait_n  = 1'b0;
  bit b_pend    = 1'b0;
  bit b_hs_n    = 1'b0;
  int b_cnt     = 0;

  // scoreboard: expected rectangle and progress
  bit          mon_en = 1'b0;
  logic [31:0] exp_dst, exp_stride, exp_color;
  int          exp_w;
  int          aw_cnt, w_row, w_beat, w_total;
  bit          irq_en_tb = 1'b0;

  // Observe the bus mid-cycle: whatever is seen here is what the next posedge handshakes.
  always @(negedge clock) begin
    logic [31:0] exp_addr;
    bit          last_exp;
    if (reset) begin
      aw_wait  = 0;
      b_wait_n = 1'b0;
      b_hs_n   = 1'b0;
    end else begin
      if (bus.awvalid && bus.awready) aw_wait = 0;
      else if (bus.awvalid)           aw_wait++;
      if (bus.wvalid && bus.wready && bus.wlast) b_wait_n = 1'b1;
      if (bus.bvalid && bus.bready)              b_hs_n   = 1'b1;

      if (mon_en) begin
        if (bus.awvalid) begin
          exp_addr = exp_dst + 32'(aw_cnt) * exp_stride;
          checks++;
          if (bus.awaddr !== exp_addr || bus.awlen !== 8'(exp_w - 1) || bus.awid !== 4'd0 ||
              bus.awsize !== 3'd3 || bus.awburst !== 2'd1) begin
            failures++;
            $display("FAIL aw_row%0d got addr=%h len=%0d id=%0d size=%0d burst=%0d exp addr=%h len=%0d",
                     aw_cnt, bus.awaddr, bus.awlen, bus.awid, bus.awsize, bus.awburst, exp_addr, exp_w - 1);
          end
          if (bus.awready) aw_cnt++;
        end
        if (bus.wvalid) begin
          checks++;
          if (aw_cnt <= w_row) begin
            failures++;
            $display("FAIL w_before_aw row=%0d got aw_count=%0d exp aw_count>%0d", w_row, aw_cnt, w_row);
          end
          if (bus.wready) begin
            last_exp = (w_beat == exp_w - 1);
            checks++;
            if (bus.wdata !== {exp_color, exp_color} || bus.wstrb !== 8'hFF || bus.wlast !== last_exp) begin
              failures++;
              $display("FAIL w_beat row=%0d beat=%0d got data=%h strb=%h last=%b exp data=%h strb=ff last=%b",
                       w_row, w_beat, bus.wdata, bus.wstrb, bus.wlast, {exp_color, exp_color}, last_exp);
            end
            w_beat++;
            w_total++;
            if (last_exp) begin
              w_row++;
              w_beat = 0;
            end
          end
        end
      end
    end
  end

  // Slave responses, updated just after each active edge.
  initial begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    forever begin
      @(posedge clock or posedge reset);
      #1;
      if (reset) begin
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        b_pend      = 1'b0;
      end else begin
        bus.awready = (aw_wait >= aw_stall);
        bus.wready  = w_toggle ? ~bus.wready : 1'b1;
        if (b_hs_n) begin
          bus.bvalid = 1'b0;
          b_hs_n     = 1'b0;
          b_cnt++;
        end
        if (b_pend) begin
          bus.bvalid = 1'b1;
          bus.bresp  = (b_cnt == err_row) ? 2'b10 : 2'b00;
          b_pend     = 1'b0;
        end
        if (b_wait_n) begin
          b_pend   = 1'b1;
          b_wait_n = 1'b0;
        end
      end
    end
  end

  task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clock);
    reg_addr  = addr;
    reg_wdata = data;
    reg_wen   = 1'b1;
    @(posedge clock);
    #1;
    reg_wen = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] addr, output logic [31:0] data);
    reg_addr = addr;
    #1;
    data = reg_rdata;
  endtask

  task automatic program_regs(input logic [31:0] dst, input int w, input int h,
                              input logic [31:0] stride, input logic [31:0] color);
    reg_write(3'd2, dst);
    reg_write(3'd3, {6'd0, 10'(h), 7'd0, 9'(w)});
    reg_write(3'd4, stride);
    reg_write(3'd5, color);
    exp_dst    = dst;
    exp_w      = w;
    exp_stride = stride;
    exp_color  = color;
    aw_cnt     = 0;
    w_row      = 0;
    w_beat     = 0;
    w_total    = 0;
    b_cnt      = 0;
    mon_en     = 1'b1;
  endtask

  task automatic run_fill(input logic [31:0] dst, input int w, input int h, input logic [31:0] stride,
                          input logic [31:0] color, input int stall, input bit toggle, input int erow);
    logic [31:0] s;
    bit          ok;
    int          rows_exp, budget;
    aw_stall = stall;
    w_toggle = toggle;
    err_row  = erow;
    program_regs(dst, w, h, stride, color);
    reg_write(3'd0, {30'd0, irq_en_tb, 1'b1});
    budget   = h * (2 * w + stall + 12) + 50;
    ok       = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #2;
      reg_read(3'd1, s);
      if (s[1]) begin
        ok = 1'b1;
        break;
      end
    end
    rows_exp = (erow >= 0) ? erow + 1 : h;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fill_timeout got done=0 after %0d cycles exp done=1", budget);
    end
    checks++;
    if (s !== {29'd0, (erow >= 0), 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL fill_status got %h exp %h", s, {29'd0, (erow >= 0), 1'b1, 1'b0});
    end
    checks++;
    if (aw_cnt != rows_exp || w_row != rows_exp || w_total != rows_exp * w) begin
      failures++;
      $display("FAIL fill_rows got aw=%0d rows=%0d beats=%0d exp aw=%0d rows=%0d beats=%0d",
               aw_cnt, w_row, w_total, rows_exp, rows_exp, rows_exp * w);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset     = 1'b1;
    reg_wen   = 1'b0;
    reg_addr  = 3'd0;
    reg_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      reg_read(3'(a), d);
      checks++;
      if (d !== 32'd0) begin
        failures++;
        $display("FAIL reset_reg%0d got %h exp 00000000", a, d);
      end
    end
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, irq} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got aw/w/b/irq=%b exp 0000",
               {bus.awvalid, bus.wvalid, bus.bready, irq});
    end
  endtask

  task automatic test_plan_fill();
    run_fill(32'h8000_0000, 200, 3, 32'd3200, 32'h00FF_0000, 0, 1'b0, -1);
  endtask

  task automatic test_stall_toggle();
    run_fill(32'h8000_0000, 200, 3, 32'd3200, 32'h00FF_0000, 5, 1'b1, -1);
  endtask

  task automatic test_bresp_err();
    logic [31:0] s;
    run_fill(32'h0100_0000, 8, 4, 32'h200, 32'h1234_5678, 0, 1'b0, 1);
    reg_write(3'd1, 32'h6);
    reg_read(3'd1, s);
    checks++;
    if (s !== 32'd0) begin
      failures++;
      $display("FAIL status_clear got %h exp 00000000", s);
    end
  endtask

  task automatic test_degenerate();
    logic [31:0] s;
    aw_stall = 0;
    w_toggle = 1'b0;
    err_row  = -1;
    program_regs(32'h2000, 0, 2, 32'h100, 32'hFFFF_FFFF);
    reg_write(3'd0, 32'h1);
    reg_read(3'd1, s);
    checks++;
    if (s !== 32'h2) begin
      failures++;
      $display("FAIL width0_status got %h exp 00000002", s);
    end
    reg_write(3'd1, 32'h6);
    reg_read(3'd1, s);
    checks++;
    if (s !== 32'h0) begin
      failures++;
      $display("FAIL width0_clear got %h exp 00000000", s);
    end
    program_regs(32'h2000, 300, 1, 32'h100, 32'hFFFF_FFFF);
    reg_write(3'd0, 32'h1);
    reg_read(3'd1, s);
    checks++;
    if (s !== 32'h6) begin
      failures++;
      $display("FAIL width300_status got %h exp 00000006", s);
    end
    repeat (5) @(posedge clock);
    checks++;
    if (aw_cnt != 0 || w_total != 0) begin
      failures++;
      $display("FAIL degenerate_traffic got aw=%0d beats=%0d exp aw=0 beats=0", aw_cnt, w_total);
    end
    reg_write(3'd1, 32'h6);
  endtask

  task automatic test_irq_busy();
    logic [31:0] s;
    bit          seen;
    irq_en_tb = 1'b1;
    aw_stall  = 0;
    w_toggle  = 1'b0;
    err_row   = -1;
    reg_write(3'd0, 32'h2);
    program_regs(32'h1000_0000, 4, 2, 32'h100, 32'hA5A5_5A5A);
    reg_write(3'd0, 32'h3);
    reg_write(3'd2, 32'hDEAD_BEE0);
    reg_write(3'd0, 32'h3);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #2;
      reg_read(3'd1, s);
      if (s[1]) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL irq_fill_timeout got done=0 exp done=1");
    end else begin
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL irq_early got %b exp 0", irq);
      end
      @(posedge clock);
      #2;
      checks++;
      if (irq !== 1'b1) begin
        failures++;
        $display("FAIL irq_rise got %b exp 1", irq);
      end
    end
    checks++;
    if (aw_cnt != 2 || w_row != 2) begin
      failures++;
      $display("FAIL busy_restart got aw=%0d rows=%0d exp aw=2 rows=2", aw_cnt, w_row);
    end
    reg_read(3'd2, s);
    checks++;
    if (s !== 32'h1000_0000) begin
      failures++;
      $display("FAIL busy_dst got %h exp 10000000", s);
    end
    reg_write(3'd1, 32'h2);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_hold got %b exp 1", irq);
    end
    @(posedge clock);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_drop got %b exp 0", irq);
    end
    irq_en_tb = 1'b0;
    reg_write(3'd0, 32'h0);
  endtask

  task automatic test_random();
    int          w, h, erow;
    logic [31:0] dst, stride, color;
    for (int n = 0; n < 6; n++) begin
      w      = $urandom_range(1, 16);
      h      = $urandom_range(1, 4);
      dst    = $urandom & 32'hFFFF_FFF8;
      stride = $urandom;
      color  = $urandom;
      erow   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, h - 1) : -1;
      run_fill(dst, w, h, stride, color, $urandom_range(0, 3), 1'($urandom_range(0, 1)), erow);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    bit          reached;
    aw_stall = 0;
    w_toggle = 1'b0;
    err_row  = -1;
    program_regs(32'h4000_0000, 200, 2, 32'h1000, 32'h0BAD_F00D);
    reg_write(3'd0, 32'h1);
    reached = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock);
      if (w_total == 50) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL reset_mid_timeout got beats=%0d exp 50", w_total);
    end
    #2;
    reset = 1'b1;
    mon_en = 1'b0;
    #1;
    reg_read(3'd1, s);
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, s[0], irq} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_mid_outputs got aw/w/b/busy/irq=%b exp 00000",
               {bus.awvalid, bus.wvalid, bus.bready, s[0], irq});
    end
    reg_read(3'd2, s);
    checks++;
    if (s !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_dst got %h exp 00000000", s);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    irq_en_tb = 1'b0;
  endtask

  task automatic test_perf();
    logic [31:0] s;
    run_fill(32'h0000_0100, 4, 1, 32'h40, 32'h7777_8888, 0, 1'b0, -1);
    reg_read(3'd6, s);
    checks++;
`ifdef VGA_FB_FILL_PERF_EN
    if (s !== 32'd7) begin
      failures++;
      $display("FAIL perf_count got %0d exp 7", s);
    end
`else
    if (s !== 32'd0) begin
      failures++;
      $display("FAIL reg6_zero got %h exp 00000000", s);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_plan_fill();
    test_stall_toggle();
    test_bresp_err();
    test_degenerate();
    test_irq_busy();
    test_random();
    test_reset_mid();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
